// File: rtl/regfile_mp.sv
// Multi-port register file: NRP registered read ports, two write ports,
// write-first bypass, optional hardwired x0 and a per-register pending scoreboard.
module regfile_mp #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int NRP      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                stall,
  input  logic                ren,
  input  logic [NRP*AW-1:0]   radd,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic                wen0,
  input  logic [AW-1:0]       wadd0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                wen1,
  input  logic [AW-1:0]       wadd1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                set_en,
  input  logic [AW-1:0]       set_add,
  output logic [NREG-1:0]     busy
);

  logic [XLEN-1:0]     regs [NREG];
  logic [NREG-1:0]     busy_q;
  logic [NREG-1:0]     busy_nxt;
  logic [AW-1:0]       ra [NRP];
  logic [NRP*XLEN-1:0] rdata_nxt;
  logic [NRP-1:0]      rbusy_nxt;
  logic                wr0_ok;
  logic                wr1_ok;

  assign busy   = busy_q;
  assign wr0_ok = wen0 && !((ZERO_REG != 0) && (wadd0 == '0));
  assign wr1_ok = wen1 && !((ZERO_REG != 0) && (wadd1 == '0));

  always_comb begin
    for (int unsigned k = 0; k < NRP; k++) begin
      ra[k] = radd[k*AW +: AW];
    end
  end

  // Clears first, then set, so a new issue overrides a same-cycle writeback.
  always_comb begin
    busy_nxt = busy_q;
    if (wen0)   busy_nxt[wadd0]   = 1'b0;
    if (wen1)   busy_nxt[wadd1]   = 1'b0;
    if (set_en) busy_nxt[set_add] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_comb begin
    rdata_nxt = '0;
    rbusy_nxt = '0;
    if (ren) begin
      for (int unsigned k = 0; k < NRP; k++) begin
        if ((ZERO_REG != 0) && (ra[k] == '0)) begin
          rdata_nxt[k*XLEN +: XLEN] = '0;
        end else if (wen1 && (wadd1 == ra[k])) begin
          rdata_nxt[k*XLEN +: XLEN] = wdata1;
        end else if (wen0 && (wadd0 == ra[k])) begin
          rdata_nxt[k*XLEN +: XLEN] = wdata0;
        end else begin
          rdata_nxt[k*XLEN +: XLEN] = regs[ra[k]];
        end
        rbusy_nxt[k] = busy_nxt[ra[k]];
      end
    end
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (!stall) begin
      if (wr0_ok) regs[wadd0] <= wdata0;
      if (wr1_ok) regs[wadd1] <= wdata1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      busy_q <= '0;
      rdata  <= '0;
      rbusy  <= '0;
    end else if (!stall) begin
      busy_q <= busy_nxt;
      rdata  <= rdata_nxt;
      rbusy  <= rbusy_nxt;
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core's 2-read/1-write register file: configurable data width, depth and number of read ports.
- Adds a second write port (late/load writeback), write-to-read bypass, optional hardwired zero register, and a per-register pending (scoreboard) bit.
- Sits between decode (reads, pending-set on issue) and writeback (writes clear pending).
- Read data is registered, 1-cycle latency, and feeds the execute stage.

Parameters:
- XLEN, 32: register data width in bits.
- NREG, 32: number of registers; power of two, >= 2.
- NRP, 2: number of read ports, 1..4.
- ZERO_REG, 1: 1 makes register 0 hardwired to zero and never pending; 0 makes it an ordinary register.
- AW (localparam), clog2(NREG): register address width.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- stall  in  1  pipeline stall; freezes all state and outputs.
- ren  in  1  read enable for all read ports.
- radd  in  NRP*AW  read addresses; port k occupies bits [k*AW +: AW].
- rdata  out  NRP*XLEN  registered read data; port k occupies [k*XLEN +: XLEN].
- rbusy  out  NRP  registered pending flag for each read port's address.
- wen0  in  1  write port 0 enable (ALU writeback).
- wadd0  in  AW  write port 0 address.
- wdata0  in  XLEN  write port 0 data.
- wen1  in  1  write port 1 enable (load/late writeback).
- wadd1  in  AW  write port 1 address.
- wdata1  in  XLEN  write port 1 data.
- set_en  in  1  mark register set_add as pending (instruction issue).
- set_add  in  AW  register to mark pending.
- busy  out  NREG  live pending vector, bit i for register i.

Behaviour:
- Reset (RSTn low, async):
  - all registers = 0; rdata = 0; rbusy = 0; busy = 0.
  - Takes effect immediately, including mid-cycle and mid-write.
- Stall (stall=1 at an edge):
  - No register, pending or output update; wen0, wen1, set_en and ren are ignored.
  - rdata and rbusy hold their previous values.
- Write (stall=0):
  - wen0 writes wdata0 to wadd0; wen1 writes wdata1 to wadd1.
  - Both enabled with the same address: port 1 wins.
  - Write to address 0 with ZERO_REG=1 is discarded.
- Read (stall=0):
  - ren=1: rdata port k <= value of radd[k] as it will be after this edge's writes (write-first bypass, port 1 over port 0 over array). Latency: 1 cycle.
  - ZERO_REG=1 and radd[k]=0: rdata port k <= 0 regardless of any write.
  - ren=0: all rdata <= 0 and all rbusy <= 0.
- Pending scoreboard (stall=0), per register i:
  - Cleared by a write from either port to i; set by set_en with set_add=i.
  - Set and clear to the same register in the same cycle: set wins (new producer issued).
  - ZERO_REG=1: busy[0] is constant 0.
  - busy is the registered state (changes 1 cycle after set/clear).
- rbusy port k <= next-state busy[radd[k]] when ren=1, consistent with the data bypass.
- Any number of read ports may read the same address; each port gets identical data and rbusy.
- Width rules:
  - No arithmetic.
  - Addresses >= NREG cannot occur because NREG is a power of two.

Test Plan:
- Reset, then ren=1 with radd0=5, radd1=31 -> rdata 0/0, rbusy 0/0; busy=0.
- wen0 to x7 with 0xDEADBEEF, same cycle radd0=7 -> next cycle rdata0=0xDEADBEEF (bypass); x7 read later still returns 0xDEADBEEF.
- wen0 and wen1 both to x3 (0x11111111 / 0x22222222) -> x3=0x22222222, and a bypass read in the same cycle also returns 0x22222222.
- ZERO_REG=1: write 0xFFFFFFFF to x0 and set_en on x0 -> read x0 = 0, busy[0] = 0. ZERO_REG=0 rerun: read x0 = 0xFFFFFFFF.
- set_en x9 -> busy[9]=1 next cycle. Then wen1 to x9 with set_en x9 in the same cycle -> busy[9] stays 1 and the data is written. A following wen0 to x9 alone -> busy[9]=0.
- stall=1 with wen0 to x4=0x5A, set_en x4, ren=1 -> x4, busy and rdata unchanged. Assert RSTn low during stall -> everything 0 immediately.
